// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_arbiter
// Purpose : Round-robin arbiter feeding one ALU from NUM_REQ issue ports
//           through a registered 1-entry output stage with flush support.
// Config  : `ALU_ARB_PERF_EN adds saturating grant/stall performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter type AE      = logic [31:0],
    parameter int  CNT_W   = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               flush_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    input  AE                  req_data_i [NUM_REQ],
    output logic               alu_valid_o,
    input  logic               alu_ready_i,
    output AE                  alu_data_o,
    output logic [IDX_W-1:0]   alu_src_o,
    output logic               busy_o
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_grant_cnt_o,
    output logic [CNT_W-1:0]   perf_stall_cnt_o
`endif
);

    localparam logic [IDX_W:0]   c_num_req = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_last    = IDX_W'(NUM_REQ - 1);

    logic               r_valid;
    AE                  r_data;
    logic [IDX_W-1:0]   r_src;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic               w_load_en;
    logic               w_any;
    logic [IDX_W-1:0]   w_grant;
    logic [IDX_W:0]     w_scan;
    logic               w_fire_in;
    logic               w_fire_out;
    logic [NUM_REQ-1:0] w_ready;

    // Reset gates acceptance so no source sees ready while reset is held.
    assign w_load_en  = reset_ni && !flush_i && (!r_valid || alu_ready_i);
    assign w_fire_in  = w_any && w_load_en;
    assign w_fire_out = r_valid && alu_ready_i;

    // First valid requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_rr_ptr;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= c_num_req) begin
                w_scan = w_scan - c_num_req;
            end
            if (!w_any && req_valid_i[w_scan[IDX_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_fire_in) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_fire_in) begin
            r_valid  <= 1'b1;
            r_data   <= req_data_i[w_grant];
            r_src    <= w_grant;
            r_rr_ptr <= (w_grant == c_last) ? '0 : w_grant + 1'b1;
        end else if (w_fire_out) begin
            r_valid <= 1'b0;
        end
    end

    assign req_ready_o = w_ready;
    assign alu_valid_o = r_valid;
    assign alu_data_o  = r_data;
    assign alu_src_o   = r_src;
    assign busy_o      = r_valid;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] r_grant_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Both counters stick at all-ones and ignore flush.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_fire_in && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + 1'b1;
            end
            if (r_valid && !alu_ready_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign perf_grant_cnt_o = r_grant_cnt;
    assign perf_stall_cnt_o = r_stall_cnt;
`else
    if (CNT_W < 1) begin : g_no_perf
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// Scoreboard bench for alu_issue_arbiter: a queue-based reference model predicts
// grants and ALU-side entries; a separate monitor checks the output stage.
module tb_alu_issue_arbiter;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    typedef logic [31:0] ae_t;

    typedef struct {
        ae_t data;
        int  src;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic         flush_i;
    logic [N-1:0] req_valid_i;
    logic [N-1:0] req_ready_o;
    ae_t          req_data_i [N];
    logic         alu_valid_o;
    logic         alu_ready_i;
    ae_t          alu_data_o;
    logic [1:0]   alu_src_o;
    logic         busy_o;
`ifdef ALU_ARB_PERF_EN
    logic [CW-1:0] perf_grant_cnt_o;
    logic [CW-1:0] perf_stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    alu_issue_arbiter #(
        .NUM_REQ (N),
        .AE      (ae_t),
        .CNT_W   (CW)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .alu_valid_o (alu_valid_o),
        .alu_ready_i (alu_ready_i),
        .alu_data_o  (alu_data_o),
        .alu_src_o   (alu_src_o),
        .busy_o      (busy_o)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (perf_grant_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // Reference state: occupancy of the output stage, next-priority source, counts.
    bit m_valid  = 1'b0;
    int m_rr     = 0;
    int m_grants = 0;
    int m_stalls = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whatever the DUT presents must be the oldest outstanding entry.
    always @(negedge clk_i) begin
        if (reset_ni) begin
            check("alu_valid", 64'(alu_valid_o), 64'(sb_q.size() != 0));
            check("busy", 64'(busy_o), 64'(sb_q.size() != 0));
            if (alu_valid_o && sb_q.size() > 0) begin
                check("alu_data", 64'(alu_data_o), 64'(sb_q[0].data));
                check("alu_src", 64'(alu_src_o), 64'(sb_q[0].src));
                if (alu_ready_i || flush_i) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // Predict the coming clock edge from the currently applied inputs.
    task automatic model_step();
        bit           load_en;
        int           g;
        logic [N-1:0] e;
        load_en = !flush_i && (!m_valid || alu_ready_i);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (g < 0 && req_valid_i[i]) g = i;
        end
        e = '0;
        if (load_en && g >= 0) e[g] = 1'b1;
        check("req_ready", 64'(req_ready_o), 64'(e));
`ifdef ALU_ARB_PERF_EN
        check("perf_grant", 64'(perf_grant_cnt_o), 64'(m_grants));
        check("perf_stall", 64'(perf_stall_cnt_o), 64'(m_stalls));
        if (m_valid && !alu_ready_i && m_stalls < CMAX) m_stalls++;
`endif
        if (flush_i) begin
            m_valid = 1'b0;
        end else if (e != '0) begin
            sb_q.push_back('{data: req_data_i[g], src: g});
            m_valid = 1'b1;
            m_rr    = (g + 1) % N;
            if (m_grants < CMAX) m_grants++;
        end else if (m_valid && alu_ready_i) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input bit fl, input logic [N-1:0] v, input bit rdy);
        @(posedge clk_i);
        #1;
        flush_i     = fl;
        req_valid_i = v;
        alu_ready_i = rdy;
        for (int i = 0; i < N; i++) req_data_i[i] = $urandom;
        @(negedge clk_i);
        #1;
        model_step();
    endtask

    task automatic reset_values_check();
        check("rst_alu_valid", 64'(alu_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_alu_src", 64'(alu_src_o), 64'd0);
        check("rst_alu_data", 64'(alu_data_o), 64'd0);
`ifdef ALU_ARB_PERF_EN
        check("rst_perf_grant", 64'(perf_grant_cnt_o), 64'd0);
        check("rst_perf_stall", 64'(perf_stall_cnt_o), 64'd0);
`endif
    endtask

    // Asynchronous reset between edges while traffic is still applied.
    task automatic async_reset();
        @(posedge clk_i);
        #3;
        reset_ni = 1'b0;
        #1;
        reset_values_check();
        sb_q.delete();
        m_valid  = 1'b0;
        m_rr     = 0;
        m_grants = 0;
        m_stalls = 0;
        @(posedge clk_i);
        #2;
        reset_ni = 1'b1;
        @(negedge clk_i);
        #1;
        model_step();
    endtask

    initial begin
        reset_ni    = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = '0;
        alu_ready_i = 1'b0;
        for (int i = 0; i < N; i++) req_data_i[i] = '0;
        #2;
        reset_values_check();
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        reset_ni = 1'b1;
        @(negedge clk_i);
        #1;
        model_step();

        // Fairness: all sources requesting, ALU always ready.
        repeat (6) cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Wrap/skip: pointer left at 3, only source 1 requesting.
        cycle(1'b0, 4'b0100, 1'b1);
        cycle(1'b0, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Backpressure: stage full, ALU stalls 3 cycles with source 2 waiting.
        cycle(1'b0, 4'b0001, 1'b0);
        repeat (3) cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Flush with stage full and every source requesting.
        cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Back-to-back swap: source 0 in the stage, source 1 loaded the same edge.
        cycle(1'b0, 4'b0001, 1'b1);
        cycle(1'b0, 4'b0010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Reset mid-transfer; first grant afterwards must come from source 0.
        cycle(1'b0, 4'b1111, 1'b0);
        req_valid_i = 4'b1111;
        async_reset();
        cycle(1'b0, 4'b0000, 1'b1);

        // Randomized traffic with occasional flush and ALU stalls.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 15) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
            if (n == 200) async_reset();
        end

        // Long stall to drive the stall counter into saturation.
        repeat (20) cycle(1'b0, 4'b1111, 1'b0);
        repeat (4) cycle(1'b0, 4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
